uart_rx: RTL and testbench
==========================

# uart_rx

Memory-mapped UART receiver, 8N1, LSB first. It is the receive-side companion to the existing UART transmitter on the same peripheral bus. It samples the `rx` pin, assembles bytes and buffers them for the CPU. It also exposes status, control and baud registers through the same address-decoded load/store interface the transmitter uses.

## Interface
- `DEFAULT_BAUD_DIVISOR`, 434: reset value of the baud register; bit period = divisor+1 clocks (115200 @ 50 MHz).
- `FIFO_DEPTH`, 4: buffer depth when `UART_RX_FIFO_EN` is defined; power of two, at least 2.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in 32: bus address.
- `write_data` in 32: store data.
- `write_enable` in 1: store strobe, one cycle per access.
- `read_enable` in 1: load strobe, one cycle per access.
- `read_data` out 32: combinational; 0 unless `read_enable` is high and the address is valid.
- `uart_rx_valid` out 1: combinational address hit on any of the four RX registers.
- `rx_irq` out 1: registered; high while the buffer is non-empty or an error flag is set.
- `rx` in 1: asynchronous serial input; idle level is high.

## Operation
- Registers, with addresses defined in the memory-map header:
  - `UART_RX_DATA` (RO): bits [7:0] are the oldest byte. A read pops it on the clock edge. A read of an empty buffer returns 0 and does not pop.
  - `UART_RX_STATUS`: bit0 `rx_avail`, bit1 `rx_full`, bit2 `overrun`, bit3 `frame_err`, bit4 `rx_busy`. Bits 2 and 3 are sticky and write-1-to-clear.
  - `UART_RX_CONTROL` (RW): bit0 `rx_enable`, reset value 1.
  - `UART_RX_BAUD` (RW): bits [15:0] hold the divisor.
- Input: `rx` passes through a 2-flop synchronizer whose flops reset to 1.
- FSM states: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: when `rx_enable` is set and the synchronized `rx` is 0, load the counter with divisor>>1 and go to `START`.
  - `START`: when the counter reaches 0, sample the line. If it is 1 (glitch), return to `IDLE` with no flags. If it is 0, reload the counter with the divisor and go to `DATA`.
  - `DATA`: at each counter zero, shift the sample into bit 7 of the shift register (LSB arrives first) and reload the counter. After 8 samples go to `STOP`.
  - `STOP`: at counter zero, sample the line. If it is 1, push the byte. If it is 0, set `frame_err` and discard the byte. Return to `IDLE` at that mid-stop-bit point, so a following start edge is caught.
- The counter counts down to 0 inclusive, matching the TX bit-period convention.
- `rx_busy` = state is not `IDLE`.
- Push while the buffer is full: drop the new byte, keep the existing contents, set `overrun`.
- Pop and push in the same cycle: both take effect. A full buffer stays full and `overrun` is not set.
- A `UART_RX_BAUD` write, or clearing `rx_enable`, aborts any frame in progress: the FSM returns to `IDLE` the next cycle. Buffered data is kept.
- On a W1C write, if the same flag is set by hardware in the same cycle, the set wins.

## Timing
- Reset values:
  - FSM `IDLE`; counter 0; shift register 0.
  - Buffer empty; status 0.
  - `rx_enable` = 1; baud = `DEFAULT_BAUD_DIVISOR`.
  - `rx_irq` = 0.
- Input latency: synchronizer delay is 2 cycles from pin to FSM.
- Start detection: the start sample is taken (divisor>>1)+1 cycles after the falling edge is seen.
- Bit sampling: each data bit is sampled divisor+1 cycles after the previous sample.
- Push latency: `rx_avail` and `rx_irq` go high 1 cycle after the stop-bit sample edge.
- Pop latency: a pop on edge N is reflected in `read_data` and status from cycle N+1.
- Reset mid-frame: the frame is lost and there is no spurious push after reset deasserts.

## Configuration
- `UART_RX_FIFO_EN` defined: circular FIFO of `FIFO_DEPTH` entries with wrap-around pointers and a count of width log2(depth)+1. `rx_full` = (count == depth).
- Undefined: a single holding register. `rx_full` equals `rx_avail`. A second byte arriving before a read sets `overrun`.

## Structure
- The following are added to the shared memory-map header: `UART_RX_DATA`, `UART_RX_STATUS`, `UART_RX_CONTROL`, `UART_RX_BAUD`, and the status bit indices.
- FSM state localparams stay local to the module.
- One sub-module: `uart_rx_fifo` (sync FIFO with push, pop, full, empty and count), instantiated only under `UART_RX_FIFO_EN`.

## Test plan
- Baud 9 (10 clk/bit): drive 0xA5 -> status bit0 = 1 one cycle after the stop sample; `RX_DATA` read = 0x000000A5; status bit0 is 0 afterwards.
- Glitch: `rx` low for 3 cycles at baud 9 -> no push, no flags, FSM returns to `IDLE`.
- Stop bit driven 0 on byte 0x3C -> status = 0x08 and nothing is pushed. Write 0x08 to status -> status = 0x00.
- Overrun without the FIFO: send 0x11 then 0x22 with no read -> read returns 0x11 and status bit2 = 1. With the FIFO: send 5 bytes -> the first 4 read in order and `overrun` is set.
- A `RX_DATA` read coincident with a push into a full FIFO -> no overrun, and byte order is preserved.
- Assert `rst` mid-`DATA`, then release -> all outputs at reset values and no byte appears. A following 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Memory map and status bit layout for the UART receiver, shared with the bus decoder.
package uart_rx_pkg;

  localparam logic [31:0] UART_RX_DATA    = 32'h1000_0010;
  localparam logic [31:0] UART_RX_STATUS  = 32'h1000_0014;
  localparam logic [31:0] UART_RX_CONTROL = 32'h1000_0018;
  localparam logic [31:0] UART_RX_BAUD    = 32'h1000_001C;

  localparam int RX_ST_AVAIL     = 0;
  localparam int RX_ST_FULL      = 1;
  localparam int RX_ST_OVERRUN   = 2;
  localparam int RX_ST_FRAME_ERR = 3;
  localparam int RX_ST_BUSY      = 4;

  function automatic logic [31:0] rx_status_word(input logic avail, input logic full,
                                                 input logic ovr, input logic ferr,
                                                 input logic busy);
    logic [31:0] w;
    w = '0;
    w[RX_ST_AVAIL]     = avail;
    w[RX_ST_FULL]      = full;
    w[RX_ST_OVERRUN]   = ovr;
    w[RX_ST_FRAME_ERR] = ferr;
    w[RX_ST_BUSY]      = busy;
    return w;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; a pop frees the slot a same-cycle push may use.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = push_ok ? wr_q + PW'(1) : wr_q;
    rd_d  = pop_ok  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push_ok) mem_q[wr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver. Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry
// receive FIFO; otherwise a single holding register buffers one byte.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter logic [15:0] DEFAULT_BAUD_DIVISOR = 16'd434,
  parameter int          FIFO_DEPTH           = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] read_data,
  output logic        uart_rx_valid,
  output logic        rx_irq,
  input  logic        rx
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        rx_meta_q, rx_sync_q;
  logic        en_q, en_d;
  logic [15:0] baud_q, baud_d;
  logic        ovr_q, ovr_d, ferr_q, ferr_d;
  logic        irq_d;

  logic hit_data, hit_status, hit_ctrl, hit_baud;
  logic wr_status, wr_ctrl, wr_baud, abort;
  logic buf_push, buf_pop, buf_full, buf_empty, buf_multi;
  logic [7:0] buf_rdata;
  logic frame_set, overrun_set, busy;

  assign hit_data      = (addr == UART_RX_DATA);
  assign hit_status    = (addr == UART_RX_STATUS);
  assign hit_ctrl      = (addr == UART_RX_CONTROL);
  assign hit_baud      = (addr == UART_RX_BAUD);
  assign uart_rx_valid = hit_data | hit_status | hit_ctrl | hit_baud;

  assign wr_status = write_enable && hit_status;
  assign wr_ctrl   = write_enable && hit_ctrl;
  assign wr_baud   = write_enable && hit_baud;
  // A new divisor or a disable makes any half-received frame meaningless.
  assign abort     = wr_baud || (wr_ctrl && !write_data[0]);

  assign buf_pop     = read_enable && hit_data && !buf_empty;
  assign overrun_set = buf_push && buf_full && !buf_pop;
  assign busy        = (state_q != IDLE);

  always_comb begin
    read_data = '0;
    if (read_enable) begin
      if (hit_data)   read_data = {24'd0, buf_rdata};
      if (hit_status) read_data = rx_status_word(!buf_empty, buf_full, ovr_q, ferr_q, busy);
      if (hit_ctrl)   read_data = {31'd0, en_q};
      if (hit_baud)   read_data = {16'd0, baud_q};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    bit_d     = bit_q;
    buf_push  = 1'b0;
    frame_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_q && !rx_sync_q) begin
          cnt_d   = baud_q >> 1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (rx_sync_q) begin
            state_d = IDLE;
          end else begin
            cnt_d   = baud_q;
            bit_d   = '0;
            state_d = DATA;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = baud_q;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          buf_push  = rx_sync_q;
          frame_set = !rx_sync_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      buf_push  = 1'b0;
      frame_set = 1'b0;
    end
  end

  // Hardware set beats a same-cycle W1C clear.
  always_comb begin
    en_d   = en_q;
    baud_d = baud_q;
    ovr_d  = ovr_q;
    ferr_d = ferr_q;
    if (wr_ctrl) en_d = write_data[0];
    if (wr_baud) baud_d = write_data[15:0];
    if (wr_status && write_data[RX_ST_OVERRUN])   ovr_d  = 1'b0;
    if (wr_status && write_data[RX_ST_FRAME_ERR]) ferr_d = 1'b0;
    if (overrun_set) ovr_d  = 1'b1;
    if (frame_set)   ferr_d = 1'b1;
    irq_d = buf_push || (!buf_empty && !buf_pop) || buf_multi || ovr_d || ferr_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      en_q      <= 1'b1;
      baud_q    <= DEFAULT_BAUD_DIVISOR;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      rx_irq    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      bit_q     <= bit_d;
      en_q      <= en_d;
      baud_q    <= baud_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      rx_irq    <= irq_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] fifo_count;
  logic          unused_ok;

  uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .pop   (buf_pop),
    .wdata (shift_q),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty),
    .count (fifo_count)
  );
  assign buf_multi = (fifo_count > CW'(1));
  assign unused_ok = ^write_data[31:16];
`else
  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic       unused_ok;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (buf_push && (!hold_vld_q || buf_pop)) begin
      hold_d     = shift_q;
      hold_vld_d = 1'b1;
    end else if (buf_pop) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign buf_rdata = hold_vld_q ? hold_q : '0;
  assign buf_full  = hold_vld_q;
  assign buf_empty = !hold_vld_q;
  assign buf_multi = 1'b0;
  assign unused_ok = ^{write_data[31:16], FIFO_DEPTH[0]};
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; works with or without UART_RX_FIFO_EN.
module tb_uart_rx;
  import uart_rx_pkg::*;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [31:0] read_data;
  logic        uart_rx_valid;
  logic        rx_irq;
  logic        rx = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rd;
  logic [7:0]  b;

  always #5 clk = ~clk;

  uart_rx #(.DEFAULT_BAUD_DIVISOR(16'd434), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .read_data    (read_data),
    .uart_rx_valid(uart_rx_valid),
    .rx_irq       (rx_irq),
    .rx           (rx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    read_enable = 1'b1;
    #1 d = read_data;
    @(negedge clk);
    read_enable = 1'b0;
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    write_data = d;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  // Start + 8 data bits; leaves the stop level driven on return.
  task automatic send_bits(input logic [7:0] v, input logic stopv);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (10) @(negedge clk);
    end
    rx = stopv;
  endtask

  task automatic send_frame(input logic [7:0] v, input logic stopv);
    send_bits(v, stopv);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state and decode
    addr = UART_RX_STATUS;
    #1;
    chk("valid_hit", {31'd0, uart_rx_valid}, 32'd1);
    chk("rdata_no_re", read_data, 32'd0);
    addr = 32'hDEAD_BEE0;
    #1;
    chk("valid_miss", {31'd0, uart_rx_valid}, 32'd0);
    @(negedge clk);
    reg_read(UART_RX_STATUS, rd);  chk("rst_status", rd, 32'h00);
    reg_read(UART_RX_CONTROL, rd); chk("rst_ctrl", rd, 32'h01);
    reg_read(UART_RX_BAUD, rd);    chk("rst_baud", rd, 32'd434);
    reg_read(UART_RX_DATA, rd);    chk("rst_data_empty", rd, 32'h00);
    chk("rst_irq", {31'd0, rx_irq}, 32'd0);

    reg_write(UART_RX_BAUD, 32'd9);
    reg_read(UART_RX_BAUD, rd);    chk("baud_rb", rd, 32'd9);
    repeat (5) @(negedge clk);

    // 0xA5: avail rises exactly one cycle after the stop-bit sample edge
    send_bits(8'hA5, 1'b1);
    repeat (7) @(negedge clk);
    chk("a5_irq_pre", {31'd0, rx_irq}, 32'd0);
    reg_read(UART_RX_STATUS, rd);  chk("a5_avail_pre", {31'd0, rd[0]}, 32'd0);
    reg_read(UART_RX_STATUS, rd);  chk("a5_avail_post", {31'd0, rd[0]}, 32'd1);
    chk("a5_irq_post", {31'd0, rx_irq}, 32'd1);
    repeat (11) @(negedge clk);
    reg_read(UART_RX_DATA, rd);    chk("a5_data", rd, 32'h0000_00A5);
    reg_read(UART_RX_STATUS, rd);  chk("a5_status_after", rd, 32'h00);
    chk("a5_irq_after", {31'd0, rx_irq}, 32'd0);

    // glitch: 3 low cycles
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    reg_read(UART_RX_STATUS, rd);  chk("glitch_busy", rd, 32'h10);
    repeat (20) @(negedge clk);
    reg_read(UART_RX_STATUS, rd);  chk("glitch_status", rd, 32'h00);
    reg_read(UART_RX_DATA, rd);    chk("glitch_data", rd, 32'h00);
    chk("glitch_irq", {31'd0, rx_irq}, 32'd0);

    // framing error on 0x3C
    send_frame(8'h3C, 1'b0);
    reg_read(UART_RX_STATUS, rd);  chk("ferr_status", rd, 32'h08);
    chk("ferr_irq", {31'd0, rx_irq}, 32'd1);
    reg_read(UART_RX_DATA, rd);    chk("ferr_no_data", rd, 32'h00);
    reg_write(UART_RX_STATUS, 32'h08);
    reg_read(UART_RX_STATUS, rd);  chk("ferr_cleared", rd, 32'h00);
    chk("ferr_irq_cleared", {31'd0, rx_irq}, 32'd0);

    // overrun: one byte more than the buffer holds
    for (int i = 0; i <= DEPTH; i++) begin
      b = 8'(8'h11 * (i + 1));
      send_frame(b, 1'b1);
    end
    reg_read(UART_RX_STATUS, rd);  chk("ovr_status_full", rd, 32'h07);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'(8'h11 * (i + 1));
      reg_read(UART_RX_DATA, rd);  chk("ovr_data", rd, {24'd0, b});
    end
    reg_read(UART_RX_STATUS, rd);  chk("ovr_status_drained", rd, 32'h04);
    chk("ovr_irq", {31'd0, rx_irq}, 32'd1);
    reg_write(UART_RX_STATUS, 32'h04);
    reg_read(UART_RX_STATUS, rd);  chk("ovr_cleared", rd, 32'h00);

    // pop coincident with push into a full buffer
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'(8'h41 + i);
      send_frame(b, 1'b1);
    end
    b = 8'(8'h41 + DEPTH);
    send_bits(b, 1'b1);
    repeat (7) @(negedge clk);
    reg_read(UART_RX_DATA, rd);    chk("coinc_pop", rd, 32'h41);
    repeat (12) @(negedge clk);
    reg_read(UART_RX_STATUS, rd);  chk("coinc_status", rd, 32'h03);
    for (int i = 1; i <= DEPTH; i++) begin
      b = 8'(8'h41 + i);
      reg_read(UART_RX_DATA, rd);  chk("coinc_order", rd, {24'd0, b});
    end
    reg_read(UART_RX_STATUS, rd);  chk("coinc_empty", rd, 32'h00);

    // baud write aborts a frame in progress
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    reg_read(UART_RX_STATUS, rd);  chk("abort_busy", rd, 32'h10);
    reg_write(UART_RX_BAUD, 32'd9);
    reg_read(UART_RX_STATUS, rd);  chk("abort_idle", rd, 32'h00);
    repeat (100) @(negedge clk);
    reg_read(UART_RX_STATUS, rd);  chk("abort_no_push", rd, 32'h00);

    // disabled receiver ignores a frame
    reg_write(UART_RX_CONTROL, 32'h0);
    reg_read(UART_RX_CONTROL, rd); chk("ctrl_off_rb", rd, 32'h00);
    send_frame(8'h66, 1'b1);
    reg_read(UART_RX_STATUS, rd);  chk("ctrl_off_status", rd, 32'h00);
    reg_write(UART_RX_CONTROL, 32'h1);

    // reset mid-DATA with a byte already buffered
    send_frame(8'h77, 1'b1);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst2_irq", {31'd0, rx_irq}, 32'd0);
    reg_read(UART_RX_STATUS, rd);  chk("rst2_status", rd, 32'h00);
    reg_read(UART_RX_CONTROL, rd); chk("rst2_ctrl", rd, 32'h01);
    reg_read(UART_RX_BAUD, rd);    chk("rst2_baud", rd, 32'd434);
    repeat (120) @(negedge clk);
    reg_read(UART_RX_STATUS, rd);  chk("rst2_no_push", rd, 32'h00);
    reg_read(UART_RX_DATA, rd);    chk("rst2_no_data", rd, 32'h00);
    reg_write(UART_RX_BAUD, 32'd9);
    send_frame(8'h5A, 1'b1);
    reg_read(UART_RX_DATA, rd);    chk("rst2_5a", rd, 32'h5A);
    reg_read(UART_RX_STATUS, rd);  chk("rst2_final", rd, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
